dm_port_arb: RTL

Two-port arbiter and access controller in front of the 4 KiB word-organised data memory (1024 × 32, synchronous read, per-byte write enables). Shares the single memory port between the CPU load/store unit (port 0) and the DMA/debug engine (port 1). Performs store lane steering, load extraction with sign/zero extension, and alignment checking. Returns one response per accepted request.

---
 rtl/dm_pkg.sv | 44 ++++
 rtl/dm_port_arb_if.sv | 63 ++++++
 rtl/dm_lane.sv | 67 ++++++
 rtl/dm_port_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg: shared encodings, response-stage record and helpers for dm_port_arb.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dm_pkg;

  localparam logic [1:0] DM_SZ_B = 2'b00;
  localparam logic [1:0] DM_SZ_H = 2'b01;
  localparam logic [1:0] DM_SZ_W = 2'b10;
  localparam logic [1:0] DM_SZ_X = 2'b11;

  localparam logic DM_PORT0 = 1'b0;
  localparam logic DM_PORT1 = 1'b1;

  localparam int DM_NPORTS = 2;

  // Everything the load path needs one cycle after acceptance.
  typedef struct packed {
    logic       valid;
    logic       port;
    logic       we;
    logic       err;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } dm_rsp_t;

  function automatic logic dm_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      DM_SZ_B: bad = 1'b0;
      DM_SZ_H: bad = off[0];
      DM_SZ_W: bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_port_arb_if.sv
// ---------------------------------------------------------------------------
// dm_port_arb_if: request/response buses of both ports plus the memory port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dm_port_arb_if;

  logic        p0_req_valid;
  logic        p0_req_ready;
  logic        p0_req_we;
  logic [31:0] p0_req_addr;
  logic [1:0]  p0_req_size;
  logic        p0_req_unsigned;
  logic [31:0] p0_req_wdata;
  logic        p0_rsp_valid;
  logic [31:0] p0_rsp_rdata;
  logic        p0_rsp_err;

  logic        p1_req_valid;
  logic        p1_req_ready;
  logic        p1_req_we;
  logic [31:0] p1_req_addr;
  logic [1:0]  p1_req_size;
  logic        p1_req_unsigned;
  logic [31:0] p1_req_wdata;
  logic        p1_rsp_valid;
  logic [31:0] p1_rsp_rdata;
  logic        p1_rsp_err;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_win;
  logic [3:0]  mem_wbyte_enable;
  logic [31:0] mem_dout;

  // Arbiter side.
  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_size,
           p0_req_unsigned, p0_req_wdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_size,
           p1_req_unsigned, p1_req_wdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    output mem_addr, mem_we, mem_win, mem_wbyte_enable,
    input  mem_dout
  );

  // Requester and memory side.
  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_size,
           p0_req_unsigned, p0_req_wdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_size,
           p1_req_unsigned, p1_req_wdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    input  mem_addr, mem_we, mem_win, mem_wbyte_enable,
    output mem_dout
  );

endinterface

`default_nettype wire

// File: rtl/dm_lane.sv
// ---------------------------------------------------------------------------
// dm_lane: combinational store lane steering and load extraction/extension.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_lane
  import dm_pkg::*;
(
  input  wire logic [1:0]  st_size_i,
  input  wire logic [1:0]  st_off_i,
  input  wire logic [31:0] st_wdata_i,
  output logic      [3:0]  st_wbe_o,
  output logic      [31:0] st_win_o,

  input  wire logic [1:0]  ld_size_i,
  input  wire logic [1:0]  ld_off_i,
  input  wire logic        ld_uns_i,
  input  wire logic [31:0] ld_dout_i,
  output logic      [31:0] ld_data_o
);

  always_comb begin
    st_wbe_o = 4'b0000;
    st_win_o = st_wdata_i;
    case (st_size_i)
      DM_SZ_B: begin
        st_wbe_o = 4'b0001 << st_off_i;
        st_win_o = {4{st_wdata_i[7:0]}};
      end
      DM_SZ_H: begin
        st_wbe_o = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_win_o = {2{st_wdata_i[15:0]}};
      end
      DM_SZ_W: begin
        st_wbe_o = 4'b1111;
        st_win_o = st_wdata_i;
      end
      default: begin
        st_wbe_o = 4'b0000;
        st_win_o = st_wdata_i;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halves are only legal on even offsets, so bit 0 of the offset is not needed.
  assign ld_byte = ld_dout_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_dout_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = '0;
    case (ld_size_i)
      DM_SZ_B: ld_data_o = ld_uns_i ? {24'h000000, ld_byte}
                                    : {{24{ld_byte[7]}}, ld_byte};
      DM_SZ_H: ld_data_o = ld_uns_i ? {16'h0000, ld_half}
                                    : {{16{ld_half[15]}}, ld_half};
      DM_SZ_W: ld_data_o = ld_dout_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_port_arb.sv
// ---------------------------------------------------------------------------
// dm_port_arb: round-robin two-port arbiter/access controller for the data RAM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_port_arb
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12
)(
  input  wire logic   clk,
  input  wire logic   rst_n,
  dm_port_arb_if.slave bus
);

  // Keep ADDR_W-bit byte space, drop the byte offset.
  localparam logic [63:0] ADDR_SPAN = 64'd1 << ADDR_W;
  localparam logic [31:0] WORD_MASK = 32'(ADDR_SPAN - 64'd1) & ~32'd3;

  logic [DM_NPORTS-1:0]       req_valid;
  logic [DM_NPORTS-1:0]       req_we;
  logic [DM_NPORTS-1:0]       req_uns;
  logic [DM_NPORTS-1:0][31:0] req_addr;
  logic [DM_NPORTS-1:0][31:0] req_wdata;
  logic [DM_NPORTS-1:0][1:0]  req_size;

  assign req_valid = {bus.p1_req_valid,    bus.p0_req_valid};
  assign req_we    = {bus.p1_req_we,       bus.p0_req_we};
  assign req_uns   = {bus.p1_req_unsigned, bus.p0_req_unsigned};
  assign req_addr  = {bus.p1_req_addr,     bus.p0_req_addr};
  assign req_wdata = {bus.p1_req_wdata,    bus.p0_req_wdata};
  assign req_size  = {bus.p1_req_size,     bus.p0_req_size};

  logic    last_q, last_d;
  logic [31:0] addr_q, addr_d;
  dm_rsp_t rsp_q, rsp_d;

  logic [DM_NPORTS-1:0] gnt;
  logic        any_gnt;
  logic        sel;
  logic        sel_we;
  logic        sel_uns;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        sel_err;
  logic        wr_en;

  // Port 0 wins a tie unless it was the most recent grantee.
  always_comb begin
    gnt    = '0;
    gnt[0] = req_valid[0] & (~req_valid[1] | (last_q == DM_PORT1));
    gnt[1] = req_valid[1] & ~gnt[0];
  end

  assign any_gnt   = |gnt;
  assign sel       = gnt[1] ? DM_PORT1 : DM_PORT0;
  assign sel_we    = req_we[sel];
  assign sel_uns   = req_uns[sel];
  assign sel_addr  = req_addr[sel];
  assign sel_wdata = req_wdata[sel];
  assign sel_size  = req_size[sel];
  assign sel_err   = dm_misaligned(sel_size, sel_addr[1:0]);
  assign wr_en     = any_gnt & sel_we & ~sel_err;

  logic [3:0]  lane_wbe;
  logic [31:0] lane_win;
  logic [31:0] lane_ld;

  dm_lane u_lane (
    .st_size_i  (sel_size),
    .st_off_i   (sel_addr[1:0]),
    .st_wdata_i (sel_wdata),
    .st_wbe_o   (lane_wbe),
    .st_win_o   (lane_win),
    .ld_size_i  (rsp_q.size),
    .ld_off_i   (rsp_q.off),
    .ld_uns_i   (rsp_q.uns),
    .ld_dout_i  (bus.mem_dout),
    .ld_data_o  (lane_ld)
  );

  always_comb begin
    last_d = last_q;
    addr_d = addr_q;
    if (any_gnt) begin
      last_d = sel;
      addr_d = sel_addr & WORD_MASK;
    end
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = any_gnt;
    rsp_d.port  = sel;
    rsp_d.we    = sel_we;
    rsp_d.err   = sel_err;
    rsp_d.size  = sel_size;
    rsp_d.uns   = sel_uns;
    rsp_d.off   = sel_addr[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= DM_PORT1;
      addr_q <= '0;
      rsp_q  <= '0;
    end else begin
      last_q <= last_d;
      addr_q <= addr_d;
      rsp_q  <= rsp_d;
    end
  end

  assign bus.p0_req_ready     = gnt[0];
  assign bus.p1_req_ready     = gnt[1];
  assign bus.mem_addr         = addr_d;
  assign bus.mem_we           = wr_en;
  assign bus.mem_win          = lane_win;
  assign bus.mem_wbyte_enable = wr_en ? lane_wbe : 4'b0000;

  logic        rsp_v0;
  logic        rsp_v1;
  logic [31:0] rsp_data;

  assign rsp_v0   = rsp_q.valid & (rsp_q.port == DM_PORT0);
  assign rsp_v1   = rsp_q.valid & (rsp_q.port == DM_PORT1);
  assign rsp_data = (rsp_q.we | rsp_q.err) ? 32'h0 : lane_ld;

  assign bus.p0_rsp_valid = rsp_v0;
  assign bus.p0_rsp_rdata = rsp_v0 ? rsp_data : 32'h0;
  assign bus.p0_rsp_err   = rsp_v0 & rsp_q.err;
  assign bus.p1_rsp_valid = rsp_v1;
  assign bus.p1_rsp_rdata = rsp_v1 ? rsp_data : 32'h0;
  assign bus.p1_rsp_err   = rsp_v1 & rsp_q.err;

endmodule

`default_nettype wire
